framebuf_port_arbiter: RTL and testbench
========================================

FRAMEBUF_PORT_ARBITER -- requirements
Module: framebuf_port_arbiter

Interface
REQ-001 Parameter Wight, default 640, frame width in pixels.
REQ-002 Parameter Height, default 480, frame height in pixels.
REQ-003 Parameter ADDR_W, default 19, frame-buffer address width.
REQ-004 Parameter DATA_W, default 3, pixel (palette index) width.
REQ-005 Parameter WFIFO_DEPTH, default 8, write FIFO depth, power of two >= 2.
REQ-006 Parameter STARVE_LIMIT, default 1024, write-starvation threshold in cycles.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 rd_req  in  1  VGA read request for this cycle; never back-pressured.
REQ-010 rd_addr  in  ADDR_W  VGA read address.
REQ-011 rd_data_valid  out  1  rd_data carries the pixel of an earlier rd_req.
REQ-012 rd_data  out  DATA_W  returned pixel, equal to ram_q.
REQ-013 wr_valid  in  1  UART-side write offered.
REQ-014 wr_ready  out  1  write FIFO accepts; transfer when wr_valid && wr_ready.
REQ-015 wr_addr  in  ADDR_W  write address (row*Wight + column).
REQ-016 wr_data  in  DATA_W  write pixel.
REQ-017 ram_addr  out  ADDR_W  single-port RAM address, registered.
REQ-018 ram_data  out  DATA_W  RAM write data, registered.
REQ-019 ram_wren  out  1  RAM write enable, registered.
REQ-020 ram_q  in  DATA_W  RAM read data; RAM read latency 2 cycles from ram_addr.
REQ-021 wr_level  out  $clog2(WFIFO_DEPTH)+1  current FIFO occupancy.
REQ-022 wr_err  out  1  sticky: an out-of-range write was accepted and dropped.
REQ-023 wr_starve  out  1  sticky: FIFO full for STARVE_LIMIT consecutive cycles.

Function
REQ-024 Per-cycle grant, FSM states G_IDLE, G_READ, G_WRITE held in a registered grant.
REQ-025 rd_req high -> next state G_READ; else FIFO non-empty -> G_WRITE; else G_IDLE.
REQ-026 Reads have absolute priority; a read is never delayed or dropped.
REQ-027 G_READ: ram_addr = registered rd_addr, ram_wren = 0.
REQ-028 G_WRITE: FIFO head popped in the deciding cycle; ram_addr/ram_data = head, ram_wren = 1.
REQ-029 G_IDLE: ram_wren = 0, ram_addr and ram_data hold previous values.
REQ-030 rd_data_valid high exactly 3 cycles after the cycle rd_req was sampled high (1 arbiter + 2 RAM); back-to-back reads give back-to-back valids, order preserved.
REQ-031 rd_data = ram_q combinationally; meaningful only when rd_data_valid = 1.
REQ-032 wr_ready = (wr_level < WFIFO_DEPTH), from registered occupancy only; a same-cycle pop does not raise wr_ready.
REQ-033 Simultaneous push and pop: wr_level unchanged, FIFO order preserved.
REQ-034 Pop never occurs when empty; push never occurs when full.
REQ-035 FIFO pointers wrap modulo WFIFO_DEPTH.
REQ-036 Write with wr_addr >= Wight*Height: accepted (handshake completes), not enqueued, wr_err set.
REQ-037 Starvation counter increments each cycle wr_level == WFIFO_DEPTH, clears otherwise, saturates; reaching STARVE_LIMIT sets wr_starve.
REQ-038 wr_err and wr_starve clear only by reset.

Reset
REQ-039 rst_n low asynchronously forces: grant G_IDLE, FIFO empty, wr_level 0, wr_ready 0 while asserted, ram_wren 0, ram_addr 0, ram_data 0, read-valid pipeline 0, rd_data_valid 0, wr_err 0, wr_starve 0, starvation counter 0.
REQ-040 Reset mid-operation discards queued writes and in-flight read valids; no RAM write occurs in or after the reset cycle until new pushes.
REQ-041 wr_ready rises in the first clock edge after rst_n deasserts.

Verification
REQ-042 Single write 0x00005/data 5, rd_req low -> ram_wren=1, ram_addr=5, ram_data=5 two edges after handshake; wr_level back to 0.
REQ-043 rd_req high 4 cycles, addrs 10..13, RAM model preloaded -> rd_data_valid high cycles 3..6, rd_data = mem[10..13] in order, ram_wren 0 throughout.
REQ-044 rd_req held high, 8 writes pushed -> wr_ready low after 8th, wr_level 8, no ram_wren; rd_req drops -> 8 consecutive writes in FIFO order, wr_ready high after first pop.
REQ-045 rd_req held high 1024 cycles with FIFO full -> wr_starve set at cycle 1024, remains after rd_req drops.
REQ-046 Write to 307200 -> handshake completes, wr_err=1, wr_level 0, no ram_wren.
REQ-047 rst_n low while wr_level=5 and reads in flight -> wr_level 0, rd_data_valid 0, ram_wren 0 immediately, no further writes after release.

Source files
------------

// File: rtl/framebuf_port_arbiter.sv
// Frame-buffer port arbiter.
// Shares one single-port RAM between a VGA scan-out reader and a UART-fed
// pixel writer. Reads are granted every cycle they are requested, so the
// raster never stalls. Writes are buffered in a small FIFO and drained in
// any cycle without a read. Out-of-frame writes are accepted but dropped and
// flagged. A FIFO that stays full too long is flagged as write starvation.
module framebuf_port_arbiter #(
    parameter int Wight        = 640,
    parameter int Height       = 480,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 3,
    parameter int WFIFO_DEPTH  = 8,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // VGA read side
    input  logic                           rd_req_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    output logic                           rd_data_valid_o,
    output logic [DATA_W-1:0]              rd_data_o,
    // UART write side
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [ADDR_W-1:0]              wr_addr_i,
    input  logic [DATA_W-1:0]              wr_data_i,
    // Single-port RAM
    output logic [ADDR_W-1:0]              ram_addr_o,
    output logic [DATA_W-1:0]              ram_data_o,
    output logic                           ram_wren_o,
    input  logic [DATA_W-1:0]              ram_q_i,
    // Status
    output logic [$clog2(WFIFO_DEPTH):0]   wr_level_o,
    output logic                           wr_err_o,
    output logic                           wr_starve_o
);

    localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_W:0]    FRAME_PIXELS = (ADDR_W + 1)'(Wight * Height);
    localparam logic [LVL_W-1:0]   LVL_FULL     = LVL_W'(WFIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX      = CNT_W'(STARVE_LIMIT);

    // Read data returns after one arbiter cycle plus two RAM cycles.
    localparam int RD_PIPE = 3;

    typedef enum logic [1:0] {
        G_IDLE  = 2'd0,
        G_READ  = 2'd1,
        G_WRITE = 2'd2
    } grant_e;

    // True when the linear pixel address lies inside the visible frame.
    function automatic logic addr_in_frame(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < FRAME_PIXELS);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    grant_e               grant_q, grant_d;

    logic [ADDR_W-1:0]    fifo_addr_q [WFIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 ready_q, ready_d;

    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_data_q, ram_data_d;
    logic                 ram_wren_q, ram_wren_d;

    logic [RD_PIPE-1:0]   rd_vld_q, rd_vld_d;

    logic                 err_q, err_d;
    logic                 starve_q, starve_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;

    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 full_s;

    // A handshake completes whenever ready is presented; only in-frame
    // pixels are actually queued. Ready is a register, so a pop in this
    // cycle cannot open the door for a push in the same cycle.
    assign accept_s = wr_valid_i && ready_q;
    assign push_s   = accept_s && addr_in_frame(wr_addr_i);
    assign pop_s    = (grant_d == G_WRITE);
    assign full_s   = (level_q == LVL_FULL);

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------

    // Grant register: one RAM owner per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= G_IDLE;
        end else begin
            grant_q <= grant_d;
        end
    end

    // Next grant: a read always wins, otherwise drain a queued write.
    always_comb begin
        grant_d = G_IDLE;
        if (rd_req_i) begin
            grant_d = G_READ;
        end else if (level_q != {LVL_W{1'b0}}) begin
            grant_d = G_WRITE;
        end else begin
            grant_d = G_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // RAM port drive
    // ------------------------------------------------------------------

    // RAM address/data/enable for the cycle being granted; idle holds the bus.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        case (grant_d)
            G_READ: begin
                ram_addr_d = rd_addr_i;
                ram_wren_d = 1'b0;
            end
            G_WRITE: begin
                ram_addr_d = fifo_addr_q[rd_ptr_q];
                ram_data_d = fifo_data_q[rd_ptr_q];
                ram_wren_d = 1'b1;
            end
            G_IDLE: begin
                ram_wren_d = 1'b0;
            end
            default: begin
                ram_wren_d = 1'b0;
            end
        endcase
    end

    // Registered RAM interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= {ADDR_W{1'b0}};
            ram_data_q <= {DATA_W{1'b0}};
            ram_wren_q <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline
    // ------------------------------------------------------------------

    // Shift a token along with each granted read until its pixel appears.
    always_comb begin
        rd_vld_d = {rd_vld_q[RD_PIPE-2:0], rd_req_i};
    end

    // Read-valid pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= {RD_PIPE{1'b0}};
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------

    // Occupancy and pointer update; pointers wrap because depth is a power of two.
    always_comb begin
        level_d  = level_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case ({push_s, pop_s})
            2'b10: begin
                level_d  = level_q + LVL_W'(1);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            2'b01: begin
                level_d  = level_q - LVL_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            2'b11: begin
                level_d  = level_q;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            default: begin
                level_d = level_q;
            end
        endcase
        ready_d = (level_d < LVL_FULL);
    end

    // FIFO control registers; ready stays low for as long as reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= {LVL_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            ready_q  <= 1'b0;
        end else begin
            level_q  <= level_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy mark,
    // so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr_i;
            fifo_data_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Error and starvation flags
    // ------------------------------------------------------------------

    // Sticky flags and the saturating full-FIFO run counter.
    always_comb begin
        starve_cnt_d = {CNT_W{1'b0}};
        if (full_s) begin
            if (starve_cnt_q == CNT_MAX) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else begin
            starve_cnt_d = {CNT_W{1'b0}};
        end
        starve_d = starve_q | (starve_cnt_d == CNT_MAX);
        err_d    = err_q | (accept_s && !addr_in_frame(wr_addr_i));
    end

    // Flag registers; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= {CNT_W{1'b0}};
            starve_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data_valid_o = rd_vld_q[RD_PIPE-1];
    assign rd_data_o       = ram_q_i;
    assign wr_ready_o      = ready_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_data_o      = ram_data_q;
    assign ram_wren_o      = ram_wren_q;
    assign wr_level_o      = level_q;
    assign wr_err_o        = err_q;
    assign wr_starve_o     = starve_q;

endmodule

// File: tb/tb_framebuf_port_arbiter.sv
// Testbench for framebuf_port_arbiter: RAM model with two-cycle read latency,
// a queue-based reference of the arbitration rules, and a negedge monitor
// that pops expected reads/writes whenever the DUT presents them.
module tb_framebuf_port_arbiter;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int AW    = 19;
    localparam int DW    = 3;
    localparam int DEPTH = 8;
    localparam int LIM   = 1024;
    localparam int FRAME = W * H;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rd_req = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_data_valid;
    logic [DW-1:0]   rd_data;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data;
    logic            ram_wren;
    logic [DW-1:0]   ram_q = '0;
    logic [3:0]      wr_level;
    logic            wr_err;
    logic            wr_starve;

    framebuf_port_arbiter #(
        .Wight(W), .Height(H), .ADDR_W(AW), .DATA_W(DW),
        .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_data_valid_o(rd_data_valid), .rd_data_o(rd_data),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_wren_o(ram_wren),
        .ram_q_i(ram_q),
        .wr_level_o(wr_level), .wr_err_o(wr_err), .wr_starve_o(wr_starve)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { int due; int d; } rd_t;

    wr_t mq[$];      // writes waiting in the arbiter FIFO
    wr_t wexp[$];    // writes that must appear on the RAM port
    rd_t rexp[$];    // reads that must return
    int  cyc = 0;
    int  m_cnt = 0;
    bit  m_ready = 0;
    bit  m_err = 0;
    bit  m_starve = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-buffer RAM: read region 0..1023 preloaded with addr[2:0].
    logic [DW-1:0] mem [0:2047];
    initial begin : ram_model
        logic [DW-1:0] q1;
        logic [DW-1:0] rdv;
        logic [10:0]   a;
        q1 = '0;
        for (int i = 0; i < 2048; i++) mem[i] = DW'(i);
        forever begin
            @(posedge clk);
            a   = ram_addr[10:0];
            rdv = mem[a];
            if (ram_wren) mem[a] = ram_data;
            ram_q = q1;
            q1    = rdv;
        end
    end

    // Reference: reads always go first, a queued write drains on any
    // read-free cycle, reads return three cycles later.
    initial begin : ref_model
        bit  pop, full, accept;
        wr_t w;
        rd_t r;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                cyc++;
                pop    = !rd_req && (mq.size() > 0);
                full   = (mq.size() == DEPTH);
                accept = wr_valid && m_ready;
                if (rd_req) begin
                    r.due = cyc + 2;
                    r.d   = int'(rd_addr) % 8;
                    rexp.push_back(r);
                end
                if (pop) wexp.push_back(mq.pop_front());
                if (accept) begin
                    if (int'(wr_addr) < FRAME) begin
                        w.a = wr_addr;
                        w.d = wr_data;
                        mq.push_back(w);
                    end else begin
                        m_err = 1;
                    end
                end
                m_cnt = full ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
                if (m_cnt == LIM) m_starve = 1;
                m_ready = (mq.size() < DEPTH);
            end
        end
    end

    // Monitor: compare status every cycle, pop scoreboard on DUT activity.
    initial begin : monitor
        rd_t r;
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("wr_level", int'(wr_level), mq.size());
                chk("wr_ready", int'(wr_ready), int'(m_ready));
                chk("wr_err", int'(wr_err), int'(m_err));
                chk("wr_starve", int'(wr_starve), int'(m_starve));
                if (rd_data_valid) begin
                    if (rexp.size() == 0) begin
                        chk("rd_spurious_valid", 1, 0);
                    end else begin
                        r = rexp.pop_front();
                        chk("rd_latency", cyc, r.due);
                        chk("rd_data", int'(rd_data), r.d);
                    end
                end else if (rexp.size() > 0 && rexp[0].due <= cyc) begin
                    r = rexp.pop_front();
                    chk("rd_missing_valid", 0, 1);
                end
                if (ram_wren) begin
                    if (wexp.size() == 0) begin
                        chk("ram_unexpected_write", 1, 0);
                    end else begin
                        w = wexp.pop_front();
                        chk("ram_wr_addr", int'(ram_addr), int'(w.a));
                        chk("ram_wr_data", int'(ram_data), int'(w.d));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rr, input int ra, input bit wv, input int wa, input int wd);
        rd_req   = rr;
        rd_addr  = AW'(ra);
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = DW'(wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic model_clear();
        mq.delete();
        wexp.delete();
        rexp.delete();
        m_ready  = 0;
        m_err    = 0;
        m_starve = 0;
        m_cnt    = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_level"}, int'(wr_level), 0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 0);
        chk({tag, "_ram_wren"}, int'(ram_wren), 0);
        chk({tag, "_rd_valid"}, int'(rd_data_valid), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_wr_err"}, int'(wr_err), 0);
        chk({tag, "_wr_starve"}, int'(wr_starve), 0);
    endtask

    initial begin : driver
        int drained;
        // power-on reset
        model_clear();
        #2;
        check_reset_outputs("por");
        chk("por_ram_data", int'(ram_data), 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(wr_ready), 1);

        // single in-frame write
        step(0, 0, 1, 5, 5);
        idle(4);

        // four back-to-back reads
        for (int i = 10; i < 14; i++) step(1, i, 0, 0, 0);
        idle(6);

        // fill FIFO under continuous reads, then starve it
        for (int i = 0; i < DEPTH; i++) step(1, i, 1, 1024 + i, i);
        step(1, 20, 0, 0, 0);
        chk("full_level", int'(wr_level), DEPTH);
        chk("full_ready", int'(wr_ready), 0);
        for (int i = 0; i < LIM + 8; i++) step(1, i % 1024, 0, 0, 0);
        chk("starve_set", int'(wr_starve), 1);
        idle(12);
        chk("starve_sticky", int'(wr_starve), 1);
        chk("drained_level", int'(wr_level), 0);

        // first out-of-frame pixel
        step(0, 0, 1, FRAME, 3);
        idle(3);
        chk("oor_err", int'(wr_err), 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 1023),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0) ? FRAME + $urandom_range(0, 1000)
                                              : 1024 + $urandom_range(0, 1023),
                 $urandom_range(0, 7));
        end
        idle(20);

        // reset with queued writes and reads in flight
        for (int i = 0; i < 5; i++) step(1, 100 + i, 1, 1500 + i, i);
        step(1, 200, 0, 0, 0);
        chk("pre_reset_level", int'(wr_level), 5);
        rd_req = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(15);
        chk("post_reset_level", int'(wr_level), 0);

        // final drain
        drained = 0;
        for (int i = 0; i < 50; i++) begin
            if (mq.size() == 0 && wexp.size() == 0 && rexp.size() == 0) begin
                drained = 1;
                break;
            end
            idle(1);
        end
        chk("scoreboard_drained", drained, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
